// File: rtl/chan_sel_pkg.sv
// Shared encodings and constants for the channel-select multiplexer.
package chan_sel_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/chan_sel_mux_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping from N-1 to 0.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          found
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] rot;
  int unsigned    pos;

  always_comb begin
    req2  = {req, req};
    // Doubling the vector lets a plain right shift implement the wrap-around search.
    rot   = req2 >> ptr;
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 32'(ptr) + i;
        if (pos >= N) pos = pos - N;
        idx   = SW'(pos);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      gnt[j] = found && (SW'(j) == idx);
    end
  end

endmodule

// File: rtl/chan_sel_mux.sv
// N-channel select/arbitrate mux with a one-entry registered output stage.
// Optional CHAN_SEL_MUX_CNT_EN adds a saturating count of completed output handshakes.
module chan_sel_mux
  import chan_sel_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] a,
  input  logic [NCH-1:0]       a_valid,
  output logic [NCH-1:0]       a_ready,
  input  logic                 mode,
  input  logic [SW-1:0]        s,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [SW-1:0]        y_ch
`ifdef CHAN_SEL_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0]     xfer_cnt
`endif
);

  localparam logic [SW:0] NCH_L = (SW+1)'(NCH);

  logic             free;
  logic             grant;
  logic             is_rr;
  logic             cand_ok;
  logic             cand_valid;
  logic [SW-1:0]    cand;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    rr_idx;
  logic             rr_found;
  logic [NCH-1:0]   rr_gnt;
  logic [WIDTH-1:0] gdata;

  rr_pick #(
    .N  (NCH),
    .SW (SW)
  ) u_rr_pick (
    .req   (a_valid),
    .ptr   (rr_ptr),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_comb begin
    free       = ~y_valid | y_ready;
    is_rr      = (mode_e'(mode) == MODE_RR);
    cand       = '0;
    cand_ok    = 1'b0;
    cand_valid = 1'b0;
    gdata      = '0;
    if (is_rr) begin
      cand    = rr_idx;
      cand_ok = rr_found;
    end else begin
      cand    = s;
      cand_ok = ({1'b0, s} < NCH_L);
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (SW'(i) == cand) begin
        cand_valid = a_valid[i];
        gdata      = a[i*WIDTH +: WIDTH];
      end
    end
    // Gating with rst keeps a_ready low for the whole reset pulse.
    grant = cand_ok & cand_valid & free & ~rst;
    a_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      a_ready[i] = grant && (is_rr ? rr_gnt[i] : (SW'(i) == cand));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      if (grant) begin
        y       <= gdata;
        y_ch    <= cand;
        y_valid <= 1'b1;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
      if (grant && is_rr) begin
        rr_ptr <= (cand == SW'(NCH-1)) ? '0 : cand + SW'(1);
      end
    end
  end

`ifdef CHAN_SEL_MUX_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (y_valid && y_ready && (xfer_cnt != '1)) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/chan_sel_mux.md
CHAN_SEL_MUX -- requirements
Module: chan_sel_mux

Interface
REQ-001 Parameter NCH, default 4: number of input channels, range 2..16.
REQ-002 Parameter WIDTH, default 8: data bits per channel, range 1..64.
REQ-003 Parameter SW, default $clog2(NCH): select and channel-index width, derived and never overridden.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 a  input  NCH*WIDTH  channel data, channel i at a[i*WIDTH +: WIDTH].
REQ-007 a_valid  input  NCH  per-channel valid.
REQ-008 a_ready  output  NCH  per-channel ready.
REQ-009 mode  input  1  0 = fixed select by s, 1 = round-robin.
REQ-010 s  input  SW  channel select used when mode=0.
REQ-011 y  output  WIDTH  registered output data.
REQ-012 y_valid  output  1  the output register holds a word.
REQ-013 y_ready  input  1  the consumer accepts y this cycle.
REQ-014 y_ch  output  SW  source channel index of the word in y.

Function
REQ-015 The block shall have a one-entry output register; free = ~y_valid | y_ready.
REQ-016 mode=0: the candidate shall be channel s; if s >= NCH there shall be no candidate.
REQ-017 mode=1: the candidate shall be the first channel with a_valid=1, searching from rr_ptr upward and wrapping from NCH-1 to 0.
REQ-018 A grant shall occur when the candidate exists, its a_valid=1, and free=1; a_ready shall be one-hot on the granted channel and all-zero otherwise.
REQ-019 On a grant, y, y_ch and y_valid=1 shall load on the next edge; latency is exactly 1 cycle.
REQ-020 When a handshake completes (y_valid & y_ready) with no grant, y_valid shall clear.
REQ-021 While y_valid=1 and y_ready=0, y and y_ch shall hold stable and all a_ready bits shall be 0.
REQ-022 Back-to-back operation (handshake and grant in the same cycle) shall sustain one word per cycle.
REQ-023 rr_ptr shall update to (granted+1) mod NCH only on a round-robin grant; it shall hold when there is no grant and in mode=0.
REQ-024 A mode or s change shall affect only the next grant decision; a held word shall not be affected.
REQ-025 a_ready shall not depend on a_valid of non-candidate channels.

Reset
REQ-026 Asserting rst at any time, including mid-transfer, shall clear y_valid to 0, y to 0, y_ch to 0 and rr_ptr to 0, and any held word shall be discarded.
REQ-027 During rst, a_ready shall be all-zero.
REQ-028 After deassertion, the first grant shall be possible on the first rising edge.

Configuration
REQ-029 When macro CHAN_SEL_MUX_CNT_EN is defined, the block shall add output xfer_cnt (16 bits): the count of completed output handshakes, saturating at 16'hFFFF, cleared by rst.
REQ-030 When CHAN_SEL_MUX_CNT_EN is not defined, the port and the counter shall be absent, and all other behaviour shall be identical.

Structure
REQ-031 Package chan_sel_pkg shall hold the mode encodings MODE_FIXED=1'b0 and MODE_RR=1'b1, plus the counter width constant CNT_W=16.
REQ-032 The round-robin search shall be a sub-module rr_pick (inputs: request vector and pointer; outputs: one-hot grant and index).
REQ-033 All other logic shall be flat within chan_sel_mux.

Verification
REQ-034 Fixed mode, defaults: a=32'hDD_CC_BB_AA, all valid, y_ready=1, s=0..3 in successive cycles -> y=AA,BB,CC,DD one cycle later each, with y_ch=0..3.
REQ-035 Round-robin: all four valid, y_ready=1 for 8 cycles -> y_ch=0,1,2,3,0,1,2,3, one word per cycle.
REQ-036 Round-robin with only channels 1 and 3 valid -> y_ch alternates 1,3,1,3; rr_ptr wraps 0 after channel 3.
REQ-037 Backpressure: y_ready=0 for 5 cycles with a word held -> y and y_ch stable, a_ready=0; y_ready=1 -> the next word follows in the following cycle.
REQ-038 rst pulse while y_valid=1 -> y_valid=0 immediately (asynchronous), and after release the round-robin restarts at channel 0.
REQ-039 Parameters NCH=3, WIDTH=16, mode=0, s=3 -> no grant, a_ready=0, y_valid stays 0; with CHAN_SEL_MUX_CNT_EN defined, 10 transfers give xfer_cnt=10.
